// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
// The destination ID always sits in the top DEST_W bits of a packet.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    WAIT_PUSH
  } sched_state_t;

  localparam int DEST_W    = 8;
  localparam int MAX_PKT_W = 256;

  // Callers zero-extend their packet to MAX_PKT_W and pass its real width.
  function automatic logic [DEST_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                 input int unsigned         pkt_w);
    return DEST_W'(pkt >> (pkt_w - DEST_W));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so ptr lands at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_arbiter #(
  parameter int num_ntrfs = 4
) (
  input  logic [num_ntrfs-1:0]         req,
  input  logic [$clog2(num_ntrfs)-1:0] ptr,
  output logic [$clog2(num_ntrfs)-1:0] gnt_idx,
  output logic                         gnt_valid
);

  localparam int IW = $clog2(num_ntrfs);
  localparam logic [IW:0] N_EXT = (IW+1)'(num_ntrfs);

  logic [2*num_ntrfs-1:0] req_dbl;
  logic [num_ntrfs-1:0]   req_rot;
  logic [IW-1:0]          enc;
  logic [IW:0]            idx_sum;

  assign req_dbl = {req, req};
  assign req_rot = num_ntrfs'(req_dbl >> ptr);

  always_comb begin
    enc = '0;
    for (int i = num_ntrfs - 1; i >= 0; i--) begin
      if (req_rot[i]) enc = IW'(i);
    end
  end

  assign idx_sum   = {1'b0, enc} + {1'b0, ptr};
  assign gnt_idx   = (idx_sum >= N_EXT) ? IW'(idx_sum - N_EXT) : IW'(idx_sum);
  assign gnt_valid = |req;

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin sequencer for the shared router bus: grant, pop the source
// FIFO, decode the destination, then push to one or all other terminals.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int          num_ntrfs = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_ntrfs-1:0]           pndng,
  input  logic [num_ntrfs*pckg_sz-1:0]   data_in,
  output logic [num_ntrfs-1:0]           pop,
  input  logic [num_ntrfs-1:0]           full,
  output logic [pckg_sz-1:0]             data_out,
  output logic [num_ntrfs-1:0]           push,
  output logic                           busy,
  output logic [15:0]                    drop_cnt
);

  localparam int IW = $clog2(num_ntrfs);
  localparam logic [DEST_W:0] NTRFS_EXT = (DEST_W+1)'(num_ntrfs);

  sched_state_t          state_reg;
  logic [IW-1:0]         rr_ptr_reg;
  logic [IW-1:0]         gnt_reg;
  logic [pckg_sz-1:0]    pkt_reg;
  logic [num_ntrfs-1:0]  mask_reg;
  logic [15:0]           drop_cnt_reg;

  logic [IW-1:0]         arb_idx;
  logic                  arb_valid;
  logic [IW-1:0]         rr_ptr_next;
  logic [pckg_sz-1:0]    head_arr [num_ntrfs];
  logic [pckg_sz-1:0]    head;
  logic [DEST_W-1:0]     dest;
  logic                  is_bcast;
  logic                  dest_valid;
  logic [num_ntrfs-1:0]  uni_mask;
  logic [num_ntrfs-1:0]  bc_mask;
  logic [num_ntrfs-1:0]  tgt_mask;
  logic                  blocked;

  rr_arbiter #(.num_ntrfs(num_ntrfs)) u_arb (
    .req       (pndng),
    .ptr       (rr_ptr_reg),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  for (genvar gi = 0; gi < num_ntrfs; gi++) begin : g_term
    assign head_arr[gi] = data_in[gi*pckg_sz +: pckg_sz];
    assign uni_mask[gi] = (dest == DEST_W'(gi));
    assign bc_mask[gi]  = (gnt_reg != IW'(gi));
    assign pop[gi]      = (state_reg == POP) && (gnt_reg == IW'(gi));
  end

  assign head       = head_arr[gnt_reg];
  assign dest       = dest_of(MAX_PKT_W'(head), pckg_sz);
  assign is_bcast   = (dest == broadcast);
  assign dest_valid = is_bcast || ({1'b0, dest} < NTRFS_EXT);
  assign tgt_mask   = is_bcast ? bc_mask : uni_mask;

  assign rr_ptr_next = (gnt_reg == IW'(num_ntrfs - 1)) ? '0 : IW'(gnt_reg + 1'b1);

  // Any full target blocks the whole push, so a broadcast is never partial.
  assign blocked  = |(mask_reg & full);
  assign push     = (state_reg == WAIT_PUSH && !blocked) ? mask_reg : '0;
  assign busy     = (state_reg != IDLE);
  assign data_out = pkt_reg;
  assign drop_cnt = drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      gnt_reg      <= '0;
      pkt_reg      <= '0;
      mask_reg     <= '0;
      drop_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_valid) begin
            gnt_reg   <= arb_idx;
            state_reg <= POP;
          end
        end
        POP: begin
          // The FWFT head is still valid on the edge that consumes the pop.
          pkt_reg <= head;
          if (dest_valid) begin
            mask_reg  <= tgt_mask;
            state_reg <= WAIT_PUSH;
          end else begin
            if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= IDLE;
          end
        end
        WAIT_PUSH: begin
          if (!blocked) begin
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Bench for bus_rr_scheduler: FWFT terminal FIFO models feed the DUT and a
// scoreboard of expected pushes is checked as pushes appear on the bus.
module tb_bus_rr_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     pndng = '0;
  logic [N*W-1:0]   data_in = '0;
  logic [N-1:0]     pop;
  logic [N-1:0]     full = '0;
  logic [W-1:0]     data_out;
  logic [N-1:0]     push;
  logic             busy;
  logic [15:0]      drop_cnt;

  typedef struct packed {
    logic [N-1:0] mask;
    logic [W-1:0] data;
  } exp_t;

  logic [W-1:0] fifo_q [N][$];
  exp_t         exp_q [$];
  logic [N-1:0] pend_pop = '0;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_rr_scheduler #(.num_ntrfs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .data_in  (data_in),
    .pop      (pop),
    .full     (full),
    .data_out (data_out),
    .push     (push),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (fifo_q[i].size() != 0);
      data_in[i*W +: W] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
    end
  endtask

  // A pop seen mid-cycle is consumed by the following rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pend_pop[i] && fifo_q[i].size() > 0) fifo_q[i].delete(0);
    end
    pend_pop = reset ? '0 : pop;
    refresh();
  end

  function automatic logic [N-1:0] model_mask(input int src, input logic [W-1:0] pkt);
    logic [7:0] d;
    d = pkt[15:8];
    if (d == 8'hFF) return ~(N'(1) << src);
    if (d < 8'd4) return N'(1) << d;
    return '0;
  endfunction

  task automatic load(input int src, input logic [W-1:0] pkt, input bit track);
    logic [N-1:0] m;
    fifo_q[src].push_back(pkt);
    m = model_mask(src, pkt);
    if (track && m != '0) exp_q.push_back('{mask: m, data: pkt});
    refresh();
  endtask

  task automatic wait_push(input int budget, output logic [N-1:0] pm,
                           output logic [W-1:0] pd, output int at, output bit ok);
    ok = 1'b0; pm = '0; pd = '0; at = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (push != '0) begin
        ok = 1'b1; pm = push; pd = data_out; at = cyc;
        $display("push mask=%b data=%h cycle=%0d", pm, pd, at);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    full  = '0;
    repeat (3) @(negedge clk);
    checks++; if (pop !== '0) begin failures++; $display("FAIL reset_pop: got %b need 0000", pop); end
    checks++; if (push !== '0) begin failures++; $display("FAIL reset_push: got %b need 0000", push); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b need 0", busy); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop: got %h need 0000", drop_cnt); end
    checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_data: got %h need 0000", data_out); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b need 0", busy); end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    full  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unicast();
    exp_t e;
    load(0, 16'h02AB, 1'b1);
    @(negedge clk);
    checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL uni_pop: got %b need 0001", pop); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL uni_busy: got %b need 1", busy); end
    @(negedge clk);
    e = exp_q.pop_front();
    $display("push mask=%b data=%h cycle=%0d", push, data_out, cyc);
    checks++; if (push !== e.mask) begin failures++; $display("FAIL uni_push: got %b need %b", push, e.mask); end
    checks++; if (data_out !== e.data) begin failures++; $display("FAIL uni_data: got %h need %h", data_out, e.data); end
    checks++; if (pop !== '0) begin failures++; $display("FAIL uni_pop_during_push: got %b need 0000", pop); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL uni_busy_after: got %b need 0", busy); end
    checks++; if (push !== '0) begin failures++; $display("FAIL uni_push_after: got %b need 0000", push); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] pm; logic [W-1:0] pd; int at; int prev; bit ok; exp_t e;
    apply_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) load(i, 16'h0000 | W'(i << 4) | W'(k), 1'b1);
    prev = 0;
    for (int p = 0; p < 2 * N; p++) begin
      wait_push(10, pm, pd, at, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL rr_timeout: push %0d got none need a push", p);
      end else if (exp_q.size() == 0) begin
        failures++; $display("FAIL rr_extra: got push %b need none", pm);
      end else begin
        e = exp_q.pop_front();
        if (pm !== e.mask || pd !== e.data) begin
          failures++; $display("FAIL rr_order: push %0d got %b/%h need %b/%h", p, pm, pd, e.mask, e.data);
        end
        if (p > 0) begin
          checks++;
          if (at - prev !== 3) begin failures++; $display("FAIL rr_spacing: got %0d need 3", at - prev); end
        end
        prev = at;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_broadcast_backpressure();
    exp_t e;
    full = 4'b0001;
    load(2, 16'hFF55, 1'b1);
    @(negedge clk);
    checks++; if (pop !== 4'b0100) begin failures++; $display("FAIL bc_pop: got %b need 0100", pop); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (push !== '0) begin failures++; $display("FAIL bc_stall_push: cycle %0d got %b need 0000", k, push); end
      checks++; if (busy !== 1'b1 || data_out !== 16'hFF55) begin
        failures++; $display("FAIL bc_stall_hold: got busy=%b data=%h need 1/ff55", busy, data_out);
      end
    end
    full = '0;
    #1;
    e = exp_q.pop_front();
    $display("push mask=%b data=%h cycle=%0d", push, data_out, cyc);
    checks++; if (push !== e.mask) begin failures++; $display("FAIL bc_push: got %b need %b", push, e.mask); end
    checks++; if (data_out !== e.data) begin failures++; $display("FAIL bc_data: got %h need %h", data_out, e.data); end
    @(negedge clk);
    checks++; if (push !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL bc_single: got push=%b busy=%b need 0000/0", push, busy);
    end
  endtask

  task automatic test_invalid_dest();
    logic [N-1:0] pm; logic [W-1:0] pd; int at; bit ok; exp_t e;
    load(1, 16'h0712, 1'b1);
    @(negedge clk);
    checks++; if (pop !== 4'b0010) begin failures++; $display("FAIL inv_pop: got %b need 0010", pop); end
    @(negedge clk);
    checks++; if (push !== '0) begin failures++; $display("FAIL inv_push: got %b need 0000", push); end
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL inv_drop: got %0d need 1", drop_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL inv_busy: got %b need 0", busy); end
    load(0, 16'h01C0, 1'b1);
    load(1, 16'h0311, 1'b1);
    @(negedge clk);
    checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL inv_next_grant: got %b need 0001", pop); end
    for (int p = 0; p < 2; p++) begin
      wait_push(10, pm, pd, at, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
        failures++; $display("FAIL inv_follow: push %0d got ok=%b need a tracked push", p, ok);
      end else begin
        e = exp_q.pop_front();
        if (pm !== e.mask || pd !== e.data) begin
          failures++; $display("FAIL inv_follow: got %b/%h need %b/%h", pm, pd, e.mask, e.data);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] pm; logic [W-1:0] pd; int at; bit ok; exp_t e;
    full = 4'b1111;
    load(0, 16'h03EE, 1'b0);
    @(negedge clk);
    checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL mid_pop: got %b need 0001", pop); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || push !== '0) begin
      failures++; $display("FAIL mid_stall: got busy=%b push=%b need 1/0000", busy, push);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (push !== '0) begin failures++; $display("FAIL mid_push: got %b need 0000", push); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b need 0", busy); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL mid_drop: got %0d need 0", drop_cnt); end
    reset = 1'b0;
    full  = '0;
    load(3, 16'h0155, 1'b1);
    @(negedge clk);
    checks++; if (pop !== 4'b1000) begin failures++; $display("FAIL mid_grant: got %b need 1000", pop); end
    wait_push(10, pm, pd, at, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      failures++; $display("FAIL mid_follow: got ok=%b need a tracked push", ok);
    end else begin
      e = exp_q.pop_front();
      if (pm !== e.mask || pd !== e.data) begin
        failures++; $display("FAIL mid_follow: got %b/%h need %b/%h", pm, pd, e.mask, e.data);
      end
    end
    repeat (4) @(negedge clk);
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left: got %0d need 0", exp_q.size()); end
    checks++; if (push !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL final_idle: got push=%b busy=%b need 0000/0", push, busy);
    end
  endtask

  initial begin
    refresh();
    test_reset();
    test_unicast();
    test_round_robin();
    test_broadcast_backpressure();
    test_invalid_dest();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_rr_scheduler.md
Name: bus_rr_scheduler

Overview:
- Round-robin scheduler that shares the single router bus between num_ntrfs terminals.
- Picks one terminal with a pending packet and pops it from that terminal's FWFT FIFO.
- Decodes the destination ID in the packet header, then pushes the packet to one destination or to all other terminals (broadcast).
- Sits between the per-terminal input FIFOs and the per-terminal output FIFOs of the bus generator. It is the sequencer the bus datapath needs.

Parameters:
- num_ntrfs, 4, number of terminals; 2..16.
- pckg_sz, 16, packet width in bits; >= 9.
- broadcast, 8'hFF, destination ID meaning "all terminals except source".

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- pndng  in  num_ntrfs  bit i = terminal i input FIFO non-empty.
- data_in  in  num_ntrfs*pckg_sz  FWFT head word of terminal i at slice [i*pckg_sz +: pckg_sz].
- pop  out  num_ntrfs  one-hot, one-cycle pop strobe to the source FIFO.
- full  in  num_ntrfs  bit i = terminal i output FIFO cannot accept a push.
- data_out  out  pckg_sz  packet driven onto the bus.
- push  out  num_ntrfs  push strobe(s) to destination FIFO(s); multi-hot on broadcast.
- busy  out  1  high whenever state != IDLE.
- drop_cnt  out  16  count of dropped packets; saturates at 16'hFFFF.

Behaviour:
- Packet format:
  - dest = data[pckg_sz-1 -: 8].
  - payload = remaining low bits.
- Reset (synchronous; takes priority over everything, including mid-transfer):
  - state=IDLE, rr_ptr=0, pop=0, push=0, data_out=0, busy=0, drop_cnt=0.
  - A packet held internally at reset is discarded and is not counted as a drop.
- States: IDLE, POP, WAIT_PUSH.
- IDLE:
  - If pndng==0, stay in IDLE.
  - Otherwise grant gnt = first set bit of pndng searching from rr_ptr upward, with wrap-around modulo num_ntrfs. Register gnt and go to POP.
- POP (exactly 1 cycle):
  - pop[gnt]=1.
  - Latch pkt = data_in slice gnt at this same edge.
  - Compute the target mask:
    - dest==broadcast: all ones except bit gnt.
    - dest<num_ntrfs: one-hot at dest. dest==gnt is legal and is delivered to the source itself.
    - Any other dest: invalid.
  - Invalid dest: increment drop_cnt (saturating), set rr_ptr=(gnt+1) mod num_ntrfs, return to IDLE. No push is issued.
  - Valid dest: go to WAIT_PUSH.
- WAIT_PUSH:
  - data_out=pkt is held stable for the whole state.
  - While (mask & full)!=0, push=0 and the state is held. There is no timeout; backpressure may stall indefinitely.
  - The first cycle (mask & full)==0: push=mask for exactly one cycle, rr_ptr=(gnt+1) mod num_ntrfs, next state IDLE.
  - A broadcast is all-or-nothing; it never issues a partial push.
- Throughput and latency:
  - Minimum 3 cycles per packet: IDLE, POP, WAIT_PUSH.
  - Push is visible 2 cycles after the grant decision.
- Fairness: a terminal that continuously has pndng set is served at most every num_ntrfs packets when all terminals are pending.
- pndng changes outside IDLE are ignored until the scheduler returns to IDLE.
- pop and push are never asserted in the same cycle.
- data_out retains the last packet value while in IDLE.

Decomposition:
- Package bus_sched_pkg:
  - state enum sched_state_t {IDLE, POP, WAIT_PUSH}.
  - DEST_W=8.
  - Helper function dest_of(pkt).
- Sub-module rr_arbiter (num_ntrfs): combinational rotate–priority-encode–unrotate.
  - Inputs: req and ptr.
  - Outputs: gnt_idx and gnt_valid.
- The FSM, packet register, mask logic and drop counter stay in the top module.

Test Plan (num_ntrfs=4, pckg_sz=16, broadcast=8'hFF):
- Unicast: reset, then term 0 presents 16'h02AB with pndng=4'b0001, full=0.
  - pop=4'b0001 on 1 cycle.
  - Next cycle push=4'b0100 and data_out=16'h02AB.
  - busy returns low the following cycle.
- Round-robin: pndng=4'b1111 held, each packet dest=0, full=0.
  - Grant order is 0,1,2,3,0.
  - Pushes are spaced exactly 3 cycles apart.
- Broadcast with backpressure: term 2 sends 16'hFF55, full=4'b0001 for 5 cycles, then 0.
  - push stays 0 during those 5 cycles.
  - Then push=4'b1011 for one cycle with data_out=16'hFF55.
- Invalid destination: term 1 sends 16'h0712.
  - pop[1] pulses, no push occurs, drop_cnt goes 0→1.
  - rr_ptr advances, so the next grant with pndng=4'b0011 goes to term 0.
- Reset mid-operation: assert reset while in WAIT_PUSH with full=4'b1111.
  - Next cycle: push=0, busy=0, drop_cnt=0.
  - After release with pndng=4'b1000, the first grant goes to term 3 (search starts from rr_ptr=0).
